// File: rtl/queue_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : queue_stream_adapter
//  Description : Pops entries from the generic delay queue through its
//                oready/re/wdata interface and presents them as a registered
//                valid/ready stream. A 2-entry skid buffer (head + skid)
//                keeps out_ready out of the combinational q_re path while
//                still sustaining one transfer per cycle. A wrapping counter
//                reports the number of delivered entries.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous active-low reset (0 = reset)
//                q_oready   - queue head entry valid on q_wdata
//                q_wdata    - queue head data
//                q_re       - pop strobe to the queue
//                out_valid  - out_data holds a valid entry
//                out_data   - head of the skid buffer
//                out_ready  - downstream accepts out_data this cycle
//                delivered  - completed transfers, modulo 2^CNT_WIDTH
//  Revision    : 1.0 - initial release
// ============================================================================
module queue_stream_adapter #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 q_oready,
    input  logic [WIDTH-1:0]     q_wdata,
    output logic                 q_re,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] delivered
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Occupancy of the skid buffer
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_head;
    logic [WIDTH-1:0]       r_skid;
    logic [WIDTH-1:0]       w_head_nxt;
    logic [WIDTH-1:0]       w_skid_nxt;
    logic                   r_valid;
    logic [CNT_WIDTH-1:0]   r_delivered;
    logic                   w_push;
    logic                   w_pop;

    // q_re looks only at registered occupancy, never at out_ready, so the
    // downstream ready path never reaches back into the queue.
    assign q_re   = rst & q_oready & (r_state != S_TWO);
    assign w_push = q_re;
    assign w_pop  = r_valid & out_ready;

    assign out_valid = r_valid;
    assign out_data  = r_head;
    assign delivered = r_delivered;

    // Next-state and next-data decode. q_wdata is only selected when
    // w_push is high, so X on an idle queue bus cannot reach the registers.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = S_ONE;
                    w_head_nxt  = q_wdata;
                end
            end
            S_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_nxt = S_TWO;
                    w_skid_nxt  = q_wdata;
                end else if (w_pop && !w_push) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_push && w_pop) begin
                    w_head_nxt  = q_wdata;
                end
            end
            S_TWO: begin
                // No push is possible here; the freed slot is refilled on
                // the following cycle.
                if (w_pop) begin
                    w_state_nxt = S_ONE;
                    w_head_nxt  = r_skid;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_EMPTY;
            r_head      <= '0;
            r_skid      <= '0;
            r_valid     <= 1'b0;
            r_delivered <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_skid  <= w_skid_nxt;
            r_valid <= (w_state_nxt != S_EMPTY);
            if (w_pop) begin
                r_delivered <= r_delivered + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_queue_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_queue_stream_adapter
//  Description : Self-checking bench for queue_stream_adapter. A source queue
//                emulates the delay queue, a FIFO-level model predicts the
//                adapter outputs, and a compare process checks every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_stream_adapter;

    localparam int c_WIDTH = 8;
    localparam int c_CNTW  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               q_oready = 1'b0;
    logic [c_WIDTH-1:0] q_wdata = '0;
    logic               q_re;
    logic               out_valid;
    logic [c_WIDTH-1:0] out_data;
    logic               out_ready = 1'b0;
    logic [c_CNTW-1:0]  delivered;

    int n_vec = 0;
    int n_err = 0;

    queue_stream_adapter #(.WIDTH(c_WIDTH), .CNT_WIDTH(c_CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_oready  (q_oready),
        .q_wdata   (q_wdata),
        .q_re      (q_re),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .delivered (delivered)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [c_WIDTH-1:0] m_buf[$];       // buffered entries, oldest first
    logic [c_WIDTH-1:0] m_head = '0;    // last value presented at the head
    logic [c_CNTW-1:0]  m_del  = '0;    // transfers modulo 2^CNT_WIDTH

    always @(negedge rst) begin
        m_buf.delete();
        m_head = '0;
        m_del  = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            bit take;
            take = q_oready && (m_buf.size() < 2);
            if (m_buf.size() > 0 && out_ready) begin
                void'(m_buf.pop_front());
                m_del = m_del + 1'b1;
            end
            if (take) m_buf.push_back(q_wdata);
            if (m_buf.size() > 0) m_head = m_buf[0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge
    always @(negedge clk) begin
        chk("q_re",      32'(q_re),      32'(rst && q_oready && (m_buf.size() < 2)));
        chk("out_valid", 32'(out_valid), 32'(m_buf.size() > 0));
        chk("out_data",  32'(out_data),  32'(m_head));
        chk("delivered", 32'(delivered), 32'(m_del));
    end

    // ---------------- stimulus ----------------
    logic [c_WIDTH-1:0] src[$];
    bit                 src_en = 1'b1;

    // One cycle: present the source head, let the edge happen, retire the
    // source entry if the adapter popped it.
    task automatic step(input bit rdy);
        bit popped;
        q_oready  = src_en && (src.size() > 0);
        q_wdata   = q_oready ? src[0] : 'x;
        out_ready = rdy;
        #3;
        popped = q_re;
        @(posedge clk);
        #1;
        if (popped) void'(src.pop_front());
    endtask

    initial begin
        // Reset and idle
        rst = 1'b0; q_oready = 1'b1; q_wdata = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q_re",  32'(q_re), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data",  32'(out_data), 0);
        chk("rst_del",   32'(delivered), 0);
        rst = 1'b1;
        repeat (2) step(1'b0);
        chk("idle_valid", 32'(out_valid), 0);

        // Single entry
        src.push_back(8'd15);
        step(1'b1);
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data",  32'(out_data), 15);
        step(1'b1);
        chk("single_empty", 32'(out_valid), 0);
        chk("single_del",   32'(delivered), 1);

        // Streaming
        src = '{8'd15, 8'd17, 8'd20, 8'd25};
        for (int i = 0; i < 6; i++) step(1'b1);
        chk("stream_del", 32'(delivered), 5);

        // Backpressure: only two entries absorbed
        src = '{8'd15, 8'd17, 8'd20};
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("bp_left",  32'(src.size()), 1);
        chk("bp_data",  32'(out_data), 15);
        step(1'b1);
        chk("bp_nopush", 32'(src.size()), 1);
        chk("bp_data2",  32'(out_data), 17);
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("bp_del", 32'(delivered), 8);

        // Mid-operation reset while full
        src = '{8'd15, 8'd17, 8'd20};
        for (int i = 0; i < 2; i++) step(1'b0);
        chk("mr_full", 32'(src.size()), 1);
        #2 rst = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_del",   32'(delivered), 0);
        chk("mr_q_re",  32'(q_re), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1);
        chk("mr_first", 32'(out_data), 20);
        step(1'b1);
        chk("mr_del1",  32'(delivered), 1);

        // Counter wrap from a clean reset
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        src.delete();
        for (int i = 0; i < 17; i++) src.push_back(c_WIDTH'(i + 1));
        for (int i = 0; i < 16; i++) step(1'b1);
        chk("wrap_15", 32'(delivered), 15);
        step(1'b1);
        chk("wrap_0",  32'(delivered), 0);
        step(1'b1);
        chk("wrap_1",  32'(delivered), 1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if (src.size() < 4 && ($urandom_range(0, 3) != 0))
                src.push_back(c_WIDTH'($urandom));
            src_en = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 2) != 0);
        end
        src_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/queue_stream_adapter.md
Name: queue_stream_adapter

Overview:
- Downstream consumer of the generic delay queue (`gendelayqueue`): drains entries via the queue's oready/re/wdata pop interface.
- Re-presents those entries as a registered valid/ready stream for the next pipeline stage.
- A 2-entry skid buffer breaks any combinational path from out_ready back to the queue's re, while sustaining one transfer per cycle.
- Also keeps a wrapping count of delivered entries for debug/perf.

Parameters:
- WIDTH, 8, data width; must match the queue's WIDTH.
- CNT_WIDTH, 16, width of the delivered-entry counter.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset, 1 = run).
- q_oready, input, 1, queue head entry valid on q_wdata.
- q_wdata, input, WIDTH, queue head data; valid whenever q_oready=1.
- q_re, output, 1, pop strobe to the queue; one entry is consumed per clk edge with q_re=1.
- out_valid, output, 1, out_data holds a valid entry.
- out_data, output, WIDTH, head of the skid buffer.
- out_ready, input, 1, downstream accepts out_data this cycle.
- delivered, output, CNT_WIDTH, number of completed out_valid&out_ready transfers, modulo 2^CNT_WIDTH.

Behaviour:
- Reset:
  - Asynchronous assertion (rst=0) clears occupancy to EMPTY, out_valid=0, out_data=0, skid register=0, delivered=0.
  - q_re is forced 0 while rst=0.
  - Release is synchronous to the next clk edge.
- Occupancy FSM: EMPTY (0 entries), ONE (head only), TWO (head + skid).
- Definitions:
  - push = q_re.
  - pop = out_valid & out_ready.
- q_re (combinational) = rst & q_oready & (state != TWO).
  - Depends only on q_oready and registered state; never on out_ready.
- Push: q_wdata is captured at the same edge q_re is high. There is no extra read latency; wdata is valid together with oready.
- Transitions:
  - EMPTY: push -> ONE, head <= q_wdata.
  - ONE, push & !pop: -> TWO, skid <= q_wdata.
  - ONE, pop & !push: -> EMPTY.
  - ONE, push & pop: stay ONE, head <= q_wdata.
  - TWO, pop: -> ONE, head <= skid. Push is impossible in TWO.
  - No event: hold state; head and skid are unchanged.
- Outputs:
  - out_valid = (state != EMPTY), registered.
  - out_data = head register.
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- Throughput:
  - Steady state with q_oready=1 and out_ready=1 runs in ONE at 1 entry/cycle.
  - Latency from queue head to out_valid is 1 cycle (q_re at edge N, out_valid from edge N).
- Ordering: strict FIFO; head is always older than skid.
- delivered: increments by 1 on each pop edge; wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
- Boundaries:
  - Queue empty (q_oready=0): no q_re; the buffer drains normally.
  - Downstream stall: at most 2 entries are absorbed, then q_re=0 until a pop.
  - The pop that frees TWO does not allow a same-cycle push; the push occurs the next cycle.
  - out_ready is ignored when out_valid=0; no counter change.
  - Reset mid-operation discards both buffered entries. Entries already popped from the queue are lost, so the queue must be reset together with this block.
- X-safety: q_wdata is not sampled when q_re=0; X on q_wdata while q_oready=0 must not propagate.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles with q_oready=1 -> q_re=0, out_valid=0, out_data=0, delivered=0. After release with q_oready=0 -> all outputs stay 0.
- Single entry: q_oready=1, q_wdata=15 for one cycle, out_ready=1 -> q_re high 1 cycle; out_valid=1, out_data=15 next cycle; then out_valid=0 and delivered=1.
- Streaming: queue presents 15,17,20,25 back-to-back with out_ready=1 -> q_re high 4 consecutive cycles; out_data 15,17,20,25 on consecutive cycles; delivered=4; state never reaches TWO.
- Backpressure: out_ready=0, queue offers 15,17,20 -> q_re high for 2 cycles only, state TWO, out_data=15 held. Raise out_ready -> 15,17,20 delivered in order; q_re for 20 occurs one cycle after the first pop.
- Mid-operation reset: in state TWO (15 head, 17 skid), pulse rst=0 asynchronously between edges -> out_valid drops immediately, delivered=0. After release, the next queued value 20 is the first delivered.
- Counter wrap: CNT_WIDTH=4, deliver 17 entries -> delivered reads 15 after the 15th transfer, then 0, then 1.
